// File: rtl/div_8by4.sv
// Sequential 8-by-4 unsigned restoring divider, one quotient bit per cycle, start/ready/valid.
// Optional macro DIV_8BY4_ZERO_CHECK_EN: detect a zero divisor at accept and answer in one cycle.
module div_8by4 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] dividend_i,
    input  logic [3:0] divisor_i,
    output logic       ready_o,
    output logic       valid_o,
    output logic [7:0] quot_o,
    output logic [3:0] rem_o,
    output logic       div_zero_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0] state_q, state_d;
    logic [7:0] dvd_q, dvd_d;
    logic [3:0] dvs_q, dvs_d;
    logic [4:0] part_q, part_d;
    logic [7:0] quo_q, quo_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] quot_out_q, quot_out_d;
    logic [3:0] rem_out_q, rem_out_d;
`ifdef DIV_8BY4_ZERO_CHECK_EN
    logic       dz_q, dz_d;
`endif

    logic [4:0] part_shift;
    logic       trial_ge;
    logic [4:0] part_next;
    logic [7:0] quo_next;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    always_comb begin
        part_shift = {part_q[3:0], dvd_q[7]};
        trial_ge   = (part_shift >= {1'b0, dvs_q});
        part_next  = trial_ge ? (part_shift - {1'b0, dvs_q}) : part_shift;
        quo_next   = {quo_q[6:0], trial_ge};
    end

    always_comb begin
        state_d    = state_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        part_d     = part_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        quot_out_d = quot_out_q;
        rem_out_d  = rem_out_q;
`ifdef DIV_8BY4_ZERO_CHECK_EN
        dz_d       = dz_q;
`endif
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    dvd_d   = dividend_i;
                    dvs_d   = divisor_i;
                    part_d  = 5'd0;
                    quo_d   = 8'd0;
                    cnt_d   = 3'd7;
                    state_d = StCalc;
`ifdef DIV_8BY4_ZERO_CHECK_EN
                    if (divisor_i == 4'd0) begin
                        state_d    = StDone;
                        quot_out_d = 8'hFF;
                        rem_out_d  = dividend_i[3:0];
                        dz_d       = 1'b1;
                    end
`endif
                end
            end
            StCalc: begin
                dvd_d  = {dvd_q[6:0], 1'b0};
                part_d = part_next;
                quo_d  = quo_next;
                if (cnt_q == 3'd0) begin
                    state_d    = StDone;
                    quot_out_d = quo_next;
                    rem_out_d  = part_next[3:0];
`ifdef DIV_8BY4_ZERO_CHECK_EN
                    dz_d       = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            dvd_q      <= 8'd0;
            dvs_q      <= 4'd0;
            part_q     <= 5'd0;
            quo_q      <= 8'd0;
            cnt_q      <= 3'd0;
            quot_out_q <= 8'd0;
            rem_out_q  <= 4'd0;
`ifdef DIV_8BY4_ZERO_CHECK_EN
            dz_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            part_q     <= part_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            quot_out_q <= quot_out_d;
            rem_out_q  <= rem_out_d;
`ifdef DIV_8BY4_ZERO_CHECK_EN
            dz_q       <= dz_d;
`endif
        end
    end

    assign ready_o = (state_q == StIdle);
    assign valid_o = (state_q == StDone);
    assign quot_o  = quot_out_q;
    assign rem_o   = rem_out_q;
`ifdef DIV_8BY4_ZERO_CHECK_EN
    assign div_zero_o = dz_q;
`else
    assign div_zero_o = 1'b0;
`endif

endmodule

// File: tb/tb_div_8by4.sv
// Self-checking bench for div_8by4: directed table, handshake corner sequences, full sweep.
module tb_div_8by4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       ready;
    logic       valid;
    logic [7:0] quot;
    logic [3:0] rem;
    logic       dz;

    int n_cmp  = 0;
    int n_fail = 0;

    div_8by4 dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .ready_o    (ready),
        .valid_o    (valid),
        .quot_o     (quot),
        .rem_o      (rem),
        .div_zero_o (dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Reference model from the arithmetic definition.
    function automatic logic [7:0] ref_quot(input logic [7:0] a, input logic [3:0] b);
        int unsigned ai = a;
        int unsigned bi = b;
        if (b == 4'd0) return 8'hFF;
        return 8'(ai / bi);
    endfunction

    function automatic logic [3:0] ref_rem(input logic [7:0] a, input logic [3:0] b);
        int unsigned ai = a;
        int unsigned bi = b;
        if (b == 4'd0) return a[3:0];
        return 4'(ai % bi);
    endfunction

    function automatic int ref_lat(input logic [3:0] b);
`ifdef DIV_8BY4_ZERO_CHECK_EN
        return (b == 4'd0) ? 1 : 9;
`else
        if (b == 4'd0) return 9;
        return 9;
`endif
    endfunction

    function automatic logic ref_dz(input logic [3:0] b);
`ifdef DIV_8BY4_ZERO_CHECK_EN
        return (b == 4'd0);
`else
        if (b == 4'd0) return 1'b0;
        return 1'b0;
`endif
    endfunction

    // Start one division from IDLE, wait (bounded) for valid, return results and latency.
    // Leaves the bench in the cycle after valid.
    task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                           output logic [7:0] q, output logic [3:0] r,
                           output logic d, output int lat);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        lat = 0;
        q = 8'd0;
        r = 4'd0;
        d = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (valid) begin
                lat = k;
                break;
            end
            tick();
        end
        if (lat == 0) check("valid_timeout", 0, 1);
        else begin
            q = quot;
            r = rem;
            d = dz;
            tick();
        end
    endtask

    vec_t        vecs[7];
    logic [7:0]  gq;
    logic [3:0]  gr;
    logic        gd;
    int          lat;

    initial begin
        vecs[0] = '{a: 8'd200, b: 4'd7,  q: 8'd28,  r: 4'd4};
        vecs[1] = '{a: 8'd255, b: 4'd1,  q: 8'd255, r: 4'd0};
        vecs[2] = '{a: 8'd9,   b: 4'd10, q: 8'd0,   r: 4'd9};
        vecs[3] = '{a: 8'd225, b: 4'd15, q: 8'd15,  r: 4'd0};
        vecs[4] = '{a: 8'd0,   b: 4'd3,  q: 8'd0,   r: 4'd0};
        vecs[5] = '{a: 8'd100, b: 4'd0,  q: 8'hFF,  r: 4'd4};
        vecs[6] = '{a: 8'd50,  b: 4'd5,  q: 8'd10,  r: 4'd0};

        rst = 1'b1;
        start = 1'b0;
        dividend = 8'd0;
        divisor = 4'd0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_ready", 32'(ready), 1);
        check("reset_valid", 32'(valid), 0);
        check("reset_quot", 32'(quot), 0);
        check("reset_rem", 32'(rem), 0);
        check("reset_dz", 32'(dz), 0);

        // 200/7 cycle by cycle.
        dividend = 8'd200;
        divisor = 4'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            check($sformatf("c%0d_valid", k), 32'(valid), (k == 9) ? 1 : 0);
            check($sformatf("c%0d_ready", k), 32'(ready), (k == 10) ? 1 : 0);
            if (k < 9) check($sformatf("c%0d_quot_hold", k), 32'(quot), 0);
            if (k == 9) begin
                check("c9_quot", 32'(quot), 28);
                check("c9_rem", 32'(rem), 4);
                check("c9_dz", 32'(dz), 0);
            end
            if (k < 10) tick();
        end

        foreach (vecs[i]) begin
            run_div(vecs[i].a, vecs[i].b, gq, gr, gd, lat);
            check($sformatf("tab%0d_quot", i), 32'(gq), 32'(vecs[i].q));
            check($sformatf("tab%0d_rem", i), 32'(gr), 32'(vecs[i].r));
            check($sformatf("tab%0d_dz", i), 32'(gd), 32'(ref_dz(vecs[i].b)));
            check($sformatf("tab%0d_lat", i), lat, ref_lat(vecs[i].b));
            check($sformatf("tab%0d_pulse", i), 32'(valid), 0);
            check($sformatf("tab%0d_ready", i), 32'(ready), 1);
        end

        // start_i during CALC must be ignored and not queued.
        dividend = 8'd200;
        divisor = 4'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        dividend = 8'd77;
        divisor = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        for (int k = 4; k <= 30; k++) begin
            if (valid) begin
                lat = k;
                break;
            end
            tick();
        end
        check("ign_lat", lat, 9);
        check("ign_quot", 32'(quot), 28);
        check("ign_rem", 32'(rem), 4);
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("ign_idle%0d_valid", k), 32'(valid), 0);
            check($sformatf("ign_idle%0d_ready", k), 32'(ready), 1);
            check($sformatf("ign_idle%0d_quot", k), 32'(quot), 28);
            check($sformatf("ign_idle%0d_rem", k), 32'(rem), 4);
        end

        // Reset in cycle 4 aborts the division.
        dividend = 8'd200;
        divisor = 4'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            check($sformatf("rst%0d_valid", k), 32'(valid), 0);
            check($sformatf("rst%0d_ready", k), 32'(ready), 1);
            check($sformatf("rst%0d_quot", k), 32'(quot), 0);
            check($sformatf("rst%0d_rem", k), 32'(rem), 0);
            check($sformatf("rst%0d_dz", k), 32'(dz), 0);
            tick();
        end
        run_div(8'd13, 4'd4, gq, gr, gd, lat);
        check("post_rst_quot", 32'(gq), 3);
        check("post_rst_rem", 32'(gr), 1);
        check("post_rst_lat", lat, 9);

        // start_i held high: re-accepted at the end of cycle 10.
        dividend = 8'd50;
        divisor = 4'd5;
        start = 1'b1;
        tick();
        for (int k = 1; k <= 10; k++) begin
            check($sformatf("b2b_c%0d_ready", k), 32'(ready), (k == 10) ? 1 : 0);
            check($sformatf("b2b_c%0d_valid", k), 32'(valid), (k == 9) ? 1 : 0);
            if (k == 9) check("b2b_first_quot", 32'(quot), 10);
            if (k == 10) begin
                dividend = 8'd225;
                divisor = 4'd15;
            end
            tick();
        end
        start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            if (valid) begin
                lat = k;
                break;
            end
            tick();
        end
        check("b2b_second_lat", lat, 9);
        check("b2b_second_quot", 32'(quot), 15);
        check("b2b_second_rem", 32'(rem), 0);
        tick();

        // All 4096 pairs in a randomized order.
        begin
            int unsigned off;
            off = $urandom;
            for (int i = 0; i < 4096; i++) begin
                int unsigned idx;
                logic [7:0] a;
                logic [3:0] b;
                idx = (32'(i) * 32'd1237 + off) & 32'hFFF;
                a = idx[11:4];
                b = idx[3:0];
                run_div(a, b, gq, gr, gd, lat);
                check($sformatf("sw %0d/%0d quot", a, b), 32'(gq), 32'(ref_quot(a, b)));
                check($sformatf("sw %0d/%0d rem", a, b), 32'(gr), 32'(ref_rem(a, b)));
                check($sformatf("sw %0d/%0d dz", a, b), 32'(gd), 32'(ref_dz(b)));
                check($sformatf("sw %0d/%0d lat", a, b), lat, ref_lat(b));
                if (b != 4'd0) begin
                    check($sformatf("sw %0d/%0d recon", a, b),
                          32'(gq) * 32'(b) + 32'(gr), 32'(a));
                    check($sformatf("sw %0d/%0d rem_lt", a, b), 32'(gr < b), 1);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/div_8by4.md
# div_8by4

Sequential unsigned divider: divides an 8-bit dividend by a 4-bit divisor and returns an 8-bit quotient and 4-bit remainder. It is the inverse companion of the team's 4-bit combinational multiplier. Both blocks share the arithmetic test harness, where div_8by4 also checks multiplier products (prod / a → b, remainder 0). It uses a restoring algorithm (one quotient bit per cycle) with a start/ready/valid handshake.

## Interface
Parameters: none (widths fixed 8/4).

- clk_i  input  1  clock; all logic on rising edge
- rst_i  input  1  reset, synchronous, active-high
- start_i  input  1  request; accepted only on a rising edge where ready_o=1
- dividend_i  input  8  unsigned dividend, sampled on accept
- divisor_i  input  4  unsigned divisor, sampled on accept
- ready_o  output  1  block idle, can accept start_i
- valid_o  output  1  one-cycle pulse: quot_o/rem_o/div_zero_o valid
- quot_o  output  8  quotient
- rem_o  output  4  remainder
- div_zero_o  output  1  last result was a divide by zero (see Configuration)

## Operation
- States: IDLE, CALC, DONE.
- IDLE: ready_o=1. On start_i=1, latch dividend into an 8-bit shift register and divisor into a 4-bit register, clear the 5-bit partial remainder R, set the iteration counter to 7, and go to CALC.
- CALC: ready_o=0. Each cycle:
  - R ← {R[3:0], dividend MSB}; shift dividend left.
  - If R ≥ {1'b0, divisor}: R ← R − divisor and shift quotient bit 1; else shift 0.
  - When the counter = 0, go to DONE; otherwise decrement.
- DONE: valid_o=1, ready_o=0. Transfer quotient and R[3:0] to quot_o/rem_o. Next state IDLE.
- Arithmetic: R never exceeds 5 bits. Final R < divisor for divisor ≠ 0, so rem_o fits in 4 bits.
- quot_o, rem_o, div_zero_o hold their values until the next DONE. They do not change in IDLE or CALC.
- start_i outside IDLE is ignored. It is not queued.
- Inputs are don't-care except on the accept edge.

## Timing
- Reset values: ready_o=1 (state IDLE), valid_o=0, quot_o=8'h00, rem_o=4'h0, div_zero_o=0. The counter and datapath registers are cleared.
- Reset mid-operation (CALC or DONE) aborts the division. The block is in IDLE with reset values in the cycle after rst_i deasserts, and no valid_o is issued.
- Reset has priority over start_i on the same edge.
- Accept on edge 0: CALC occupies cycles 1–8, valid_o=1 in cycle 9, ready_o=1 again in cycle 10.
- Normal latency is accept-to-valid 9 cycles, with a throughput of one division per 10 cycles.
- Back-to-back: start_i held high is accepted again at the end of cycle 10.

## Configuration
- Macro DIV_8BY4_ZERO_CHECK_EN.
- Defined:
  - A divisor of 0 at accept bypasses CALC; IDLE goes directly to DONE.
  - valid_o=1 in cycle 1, with quot_o=8'hFF, rem_o=dividend_i[3:0], div_zero_o=1.
  - Any nonzero-divisor result clears div_zero_o.
- Not defined:
  - No zero detection; div_zero_o is tied 0.
  - A divisor of 0 runs the full 8 iterations and naturally yields quot_o=8'hFF, rem_o=dividend_i[3:0], valid_o in cycle 9.

## Test plan
- Reset, then dividend 200, divisor 7 → valid_o in cycle 9 only, quot_o=28, rem_o=4, div_zero_o=0, ready_o=1 in cycle 10.
- Edge cases:
  - 255/1 → quot 255, rem 0.
  - 9/10 → quot 0, rem 9.
  - 225/15 → quot 15, rem 0.
  - 0/3 → quot 0, rem 0.
- 100/0 → quot 8'hFF, rem 4.
  - With DIV_8BY4_ZERO_CHECK_EN: valid_o in cycle 1, div_zero_o=1.
  - Without it: valid_o in cycle 9, div_zero_o=0.
  - Then 50/5 → quot 10, rem 0, div_zero_o=0.
- Pulse start_i with 77/3 during CALC of 200/7 → ignored; only the 28/4 result appears, and outputs stay stable through the next IDLE.
- Assert rst_i in cycle 4 of 200/7 → no valid_o; outputs return to reset values. Next start with 13/4 → quot 3, rem 1.
- Random sweep of all 4096 dividend/divisor pairs, with divisor ≠ 0 → quot*divisor+rem == dividend and rem < divisor.
